// File: rtl/mantissa_divider_11b.sv
// Sequential restoring divider for 11-bit normalized mantissas: one quotient bit per
// cycle, 14 iterations, 13 result bits (significand + R + G) plus sticky/norm/div-by-zero.
module mantissa_divider_11b (
    input  logic        clk,
    input  logic        nRST,
    input  logic        start,
    input  logic [10:0] a,
    input  logic [10:0] b,
    output logic        busy,
    output logic        done,
    output logic [12:0] result,
    output logic        norm,
    output logic        round_loss,
    output logic        div_by_zero
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [11:0] rem_r;
    logic [11:0] rem_nxt_s;
    logic [11:0] diff_s;
    logic [10:0] dvs_r;
    logic [13:0] quo_r;
    logic [13:0] quo_nxt_s;
    logic [3:0]  cnt_r;
    logic        accept_s;
    logic        ge_s;
    logic        last_s;
    logic        busy_r;
    logic        done_r;
    logic [12:0] result_r;
    logic        norm_r;
    logic        round_loss_r;
    logic        div_by_zero_r;

    // One restoring step; r < 2d keeps the shifted remainder inside 12 bits.
    always_comb begin
        accept_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        ge_s      = (rem_r >= {1'b0, dvs_r});
        diff_s    = rem_r - {1'b0, dvs_r};
        last_s    = (cnt_r == 4'd13);
        quo_nxt_s = {quo_r[12:0], ge_s};
        if (ge_s) begin
            rem_nxt_s = {diff_s[10:0], 1'b0};
        end else begin
            rem_nxt_s = {rem_r[10:0], 1'b0};
        end
    end

    // Next-state decode; a zero divisor skips straight to DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    if (b == 11'd0) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_DIV;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DIV;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, datapath and result registers; result fields only change on entry to DONE.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_r       <= ST_IDLE;
            rem_r         <= 12'd0;
            dvs_r         <= 11'd0;
            quo_r         <= 14'd0;
            cnt_r         <= 4'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            result_r      <= 13'd0;
            norm_r        <= 1'b0;
            round_loss_r  <= 1'b0;
            div_by_zero_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_DIV);
            done_r  <= (state_nxt_s == ST_DONE);
            if (accept_s) begin
                if (b == 11'd0) begin
                    result_r      <= 13'h1FFF;
                    norm_r        <= 1'b0;
                    round_loss_r  <= 1'b0;
                    div_by_zero_r <= 1'b1;
                end else begin
                    rem_r <= {1'b0, a};
                    dvs_r <= b;
                    quo_r <= 14'd0;
                    cnt_r <= 4'd0;
                end
            end else if (state_r == ST_DIV) begin
                rem_r <= rem_nxt_s;
                quo_r <= quo_nxt_s;
                cnt_r <= cnt_r + 4'd1;
                if (last_s) begin
                    div_by_zero_r <= 1'b0;
                    if (quo_nxt_s[13]) begin
                        result_r     <= quo_nxt_s[13:1];
                        norm_r       <= 1'b0;
                        round_loss_r <= quo_nxt_s[0] | (rem_nxt_s != 12'd0);
                    end else begin
                        result_r     <= quo_nxt_s[12:0];
                        norm_r       <= 1'b1;
                        round_loss_r <= (rem_nxt_s != 12'd0);
                    end
                end
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign result      = result_r;
    assign norm        = norm_r;
    assign round_loss  = round_loss_r;
    assign div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_mantissa_divider_11b.sv
// Directed self-checking bench for mantissa_divider_11b: latency, quotient fields,
// divide-by-zero, start-while-busy, back-to-back throughput and mid-divide reset.
module tb_mantissa_divider_11b;

    logic        clk = 1'b0;
    logic        nRST;
    logic        start;
    logic [10:0] a;
    logic [10:0] b;
    logic        busy;
    logic        done;
    logic [12:0] result;
    logic        norm;
    logic        round_loss;
    logic        div_by_zero;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mantissa_divider_11b dut (
        .clk(clk), .nRST(nRST), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .norm(norm),
        .round_loss(round_loss), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Accept one divide, wait (bounded) for done, check latency and fields, then leave DONE.
    task automatic run_div(input string tag, input logic [10:0] av, input logic [10:0] bv,
                           input int lat, input logic [12:0] er, input logic en,
                           input logic erl, input logic edz);
        int n;
        a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk({tag, ".latency"}, n, lat);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".result"}, {19'd0, result}, {19'd0, er});
        chk({tag, ".norm"}, {31'd0, norm}, {31'd0, en});
        chk({tag, ".round_loss"}, {31'd0, round_loss}, {31'd0, erl});
        chk({tag, ".div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edz});
        tick();
    endtask

    initial begin
        int n;
        int dones;
        logic [23:0] num;
        logic [13:0] q;
        logic [10:0] rm;
        logic [10:0] ra;
        logic [10:0] rb;

        nRST = 1'b0; start = 1'b0; a = 11'd0; b = 11'd0;
        #1;
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk("reset.result", {19'd0, result}, 32'd0);
        chk("reset.flags", {29'd0, norm, round_loss, div_by_zero}, 32'd0);
        tick(); tick();
        nRST = 1'b1;
        tick();

        run_div("one", 11'h400, 11'h400, 15, 13'h1000, 1'b0, 1'b0, 1'b0);
        run_div("two_thirds", 11'h400, 11'h600, 15, 13'h1555, 1'b1, 1'b1, 1'b0);
        chk("hold_in_idle.result", {19'd0, result}, 32'h1555);
        run_div("max_over_one", 11'h7FF, 11'h400, 15, 13'h1FFC, 1'b0, 1'b0, 1'b0);
        run_div("sticky_rem", 11'h7FF, 11'h401, 15, 13'h1FF4, 1'b0, 1'b1, 1'b0);
        run_div("min_over_max", 11'h400, 11'h7FF, 15, 13'h1002, 1'b1, 1'b1, 1'b0);

        // Start pulse and operand churn while busy must not disturb the running divide.
        a = 11'h600; b = 11'h400; start = 1'b1;
        tick();
        n = 1;
        while (!done && n < 40) begin
            a = 11'($urandom);
            b = 11'($urandom);
            if (n == 5) begin
                a = 11'h400; b = 11'h600; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        chk("midop.latency", n, 15);
        chk("midop.result", {19'd0, result}, 32'h1800);
        chk("midop.flags", {30'd0, norm, round_loss}, 32'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dones++;
        end
        chk("midop.no_second_done", dones, 0);

        run_div("dbz", 11'h5A5, 11'h000, 1, 13'h1FFF, 1'b0, 1'b0, 1'b1);
        chk("dbz_hold.div_by_zero", {31'd0, div_by_zero}, 32'd1);
        run_div("dbz_clear", 11'h7FF, 11'h7FF, 15, 13'h1000, 1'b0, 1'b0, 1'b0);

        // Held start: done at 15, 30, 45 after the first accept, busy elsewhere.
        a = 11'h400; b = 11'h400; start = 1'b1;
        tick();
        for (int k = 1; k <= 45; k++) begin
            chk($sformatf("b2b.done@%0d", k), {31'd0, done}, {31'd0, (k % 15) == 0});
            chk($sformatf("b2b.busy@%0d", k), {31'd0, busy}, {31'd0, (k % 15) != 0});
            if (k == 39) start = 1'b0;
            tick();
        end
        chk("b2b.result", {19'd0, result}, 32'h1000);

        // Asynchronous reset at iteration 7 clears everything with no done.
        a = 11'h400; b = 11'h600; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        nRST = 1'b0;
        #1;
        chk("rst_mid.busy", {31'd0, busy}, 32'd0);
        chk("rst_mid.done", {31'd0, done}, 32'd0);
        chk("rst_mid.result", {19'd0, result}, 32'd0);
        chk("rst_mid.flags", {29'd0, norm, round_loss, div_by_zero}, 32'd0);
        tick();
        nRST = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dones++;
        end
        chk("rst_mid.no_done", dones, 0);
        run_div("after_rst", 11'h7FF, 11'h7FF, 15, 13'h1000, 1'b0, 1'b0, 1'b0);

        // Short random sweep of normalized operands against an arithmetic model.
        for (int i = 0; i < 30; i++) begin
            ra  = 11'h400 | 11'($urandom);
            rb  = 11'h400 | 11'($urandom);
            num = {ra, 13'd0};
            q   = 14'(num / {13'd0, rb});
            rm  = 11'(num % {13'd0, rb});
            if (q[13]) begin
                run_div($sformatf("rand%0d", i), ra, rb, 15, q[13:1], 1'b0,
                        q[0] | (rm != 11'd0), 1'b0);
            end else begin
                run_div($sformatf("rand%0d", i), ra, rb, 15, q[12:0], 1'b1,
                        (rm != 11'd0), 1'b0);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
